// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
//
// Purpose : Shared definitions for the data-memory arbiter slice: the FSM
//           state encoding, the default port widths and the width of the
//           small saturating counters that track DMA starvation and burst
//           length.
//
// Contents:
//   S_CPU / S_DMA   - 1-bit FSM state encodings
//   DEF_ADDR_W      - default address width
//   DEF_DATA_W      - default data width
//   CNT_W           - width of the starvation / beat counters
//   to_cnt()        - narrows an integer limit to a counter-width value
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Both counters only ever need to reach 15.
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return CNT_W'(value);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// ---------------------------------------------------------------------------
// arb_sat_counter
//
// Purpose : Small up-counter that stops at a programmable limit. The arbiter
//           uses one instance to count consecutive denied DMA cycles and one
//           to count beats inside a DMA burst.
//
// Ports:
//   clk    in   clock, rising edge
//   clrn   in   asynchronous active-low clear
//   inc    in   count up by one (ignored once count has reached limit)
//   clr    in   synchronous clear to zero, wins over inc
//   limit  in   saturation value
//   count  out  current count
// ---------------------------------------------------------------------------
module arb_sat_counter
    import dmem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose : Shares the single-port data RAM between the CPU MEM stage
//           (port C) and a DMA/loader engine (port D). The CPU normally wins,
//           but the DMA is force-granted after STARVE_MAX consecutive denied
//           cycles. Once a DMA burst has started it may keep the RAM for at
//           most BURST_MAX consecutive beats. The CPU is stalled whenever it
//           requests but is not granted.
//
// Ports:
//   clk, clrn                     clock / asynchronous active-low reset
//   c_req, c_we, c_addr, c_wdata  CPU request fields (held until granted)
//   c_gnt, c_stall                CPU grant and pipeline stall (combinational)
//   c_rvalid, c_rdata             CPU read return, one cycle after grant
//   d_req, d_we, d_last,
//   d_addr, d_wdata               DMA request fields (held until granted)
//   d_gnt                         DMA grant (combinational)
//   d_rvalid, d_rdata             DMA read return, one cycle after grant
//   ram_we, ram_addr, ram_wdata   RAM command, driven by the granted port
//   ram_rdata                     RAM read data, one cycle after address
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic              clk,
    input  logic              clrn,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_last,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = to_cnt(STARVE_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM  = to_cnt(BURST_MAX);
    localparam logic [CNT_W-1:0] BURST_LAST = to_cnt(BURST_MAX - 1);
    // A burst limit of one means every DMA beat is a standalone grant.
    localparam logic             BURST_EN   = (BURST_MAX > 1);

    logic [0:0]       state;
    logic [0:0]       next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             starve_inc;
    logic             starve_clr;
    logic             beat_inc;
    logic             beat_clr;

    // Grant selection. Grants are masked while clrn is low so that nothing
    // reaches the RAM during reset, including the moment reset is asserted
    // in the middle of a burst.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (clrn) begin
            if (state == S_CPU) begin
                c_gnt = c_req && (starve_cnt < STARVE_LIM);
                d_gnt = !c_gnt && d_req;
            end else begin
                // A DMA that drops its request ends the burst and hands the
                // same cycle to the CPU.
                d_gnt = d_req;
                c_gnt = !d_req && c_req;
            end
        end
    end

    assign c_stall = c_req && !c_gnt;

    // Next-state logic. A burst ends on its last beat, on the beat that
    // reaches the burst cap, or as soon as the DMA stops requesting.
    always_comb begin
        next_state = state;
        if (state == S_CPU) begin
            if (d_gnt && !d_last && BURST_EN) begin
                next_state = S_DMA;
            end
        end else begin
            if (!d_req || (d_gnt && (d_last || (beat_cnt == BURST_LAST)))) begin
                next_state = S_CPU;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_CPU;
        end else begin
            state <= next_state;
        end
    end

    // Starvation tracking: only cycles where the DMA asks and is refused
    // count; any DMA grant or idle DMA cycle resets the count.
    assign starve_inc = d_req && !d_gnt;
    assign starve_clr = d_gnt || !d_req;

    arb_sat_counter u_starve_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .limit (STARVE_LIM),
        .count (starve_cnt)
    );

    // Beat tracking: the entry beat takes the count from 0 to 1, every
    // further beat inside the burst adds one, and leaving the burst clears.
    assign beat_inc = d_gnt && (next_state == S_DMA);
    assign beat_clr = (next_state == S_CPU);

    arb_sat_counter u_beat_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (beat_inc),
        .clr   (beat_clr),
        .limit (BURST_LIM),
        .count (beat_cnt)
    );

    // RAM command mux; an idle RAM sees an all-zero command.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (c_gnt) begin
            ram_we    = c_we;
            ram_addr  = c_addr;
            ram_wdata = c_wdata;
        end else if (d_gnt) begin
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    // Read-return tags. Reset clears them, so data in flight at reset never
    // shows up as valid.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_gnt && !c_we;
            d_rvalid <= d_gnt && !d_we;
        end
    end

    assign c_rdata = ram_rdata;
    assign d_rdata = ram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Purpose : Directed self-checking bench for dmem_arbiter with the default
//           parameters (STARVE_MAX = 4, BURST_MAX = 4). Inputs change on the
//           falling clock edge and outputs are sampled 1 time unit later, well
//           away from the rising edge where the design updates.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        clrn;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_stall;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req;
    logic        d_we;
    logic        d_last;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int compared;
    int mismatched;

    dmem_arbiter dut (
        .clk       (clk),
        .clrn      (clrn),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_stall   (c_stall),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_last    (d_last),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Waits for the falling edge, drives one cycle of request fields and
    // leaves 1 time unit for the combinational outputs to settle.
    task automatic applyStimulus(input logic cr, input logic cw,
                                 input logic [31:0] ca, input logic [31:0] cd,
                                 input logic dr, input logic dw, input logic dl,
                                 input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        c_req   = cr;
        c_we    = cw;
        c_addr  = ca;
        c_wdata = cd;
        d_req   = dr;
        d_we    = dw;
        d_last  = dl;
        d_addr  = da;
        d_wdata = dd;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        ram_rdata  = 32'h0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_last = 1'b0; d_addr = '0; d_wdata = '0;
        clrn = 1'b1;
        #1 clrn = 1'b0;

        // Reset held with both ports requesting writes.
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h11, 1'b1, 1'b1, 1'b0, 32'h200, 32'h22);
        checkOutput("rst_c_gnt",    {31'b0, c_gnt},    32'd0);
        checkOutput("rst_d_gnt",    {31'b0, d_gnt},    32'd0);
        checkOutput("rst_c_rvalid", {31'b0, c_rvalid}, 32'd0);
        checkOutput("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        checkOutput("rst_ram_we",   {31'b0, ram_we},   32'd0);

        // Release: CPU read wins the first cycle.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        clrn = 1'b1;
        #1;
        checkOutput("rel_c_gnt", {31'b0, c_gnt}, 32'd1);
        checkOutput("rel_d_gnt", {31'b0, d_gnt}, 32'd0);

        idleCycle();
        checkOutput("rel_c_rvalid", {31'b0, c_rvalid}, 32'd1);
        checkOutput("rel_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // CPU only: read 0x10 then write 0xDEADBEEF to 0x14.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("cpu_rd_gnt",   {31'b0, c_gnt},   32'd1);
        checkOutput("cpu_rd_stall", {31'b0, c_stall}, 32'd0);
        checkOutput("cpu_rd_addr",  ram_addr,         32'h10);
        checkOutput("cpu_rd_we",    {31'b0, ram_we},  32'd0);

        applyStimulus(1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        ram_rdata = 32'h12345678;
        #1;
        checkOutput("cpu_rd_rvalid", {31'b0, c_rvalid}, 32'd1);
        checkOutput("cpu_rd_rdata",  c_rdata,           32'h12345678);
        checkOutput("cpu_wr_we",     {31'b0, ram_we},   32'd1);
        checkOutput("cpu_wr_addr",   ram_addr,          32'h14);
        checkOutput("cpu_wr_wdata",  ram_wdata,         32'hDEADBEEF);

        idleCycle();
        checkOutput("cpu_wr_no_rvalid", {31'b0, c_rvalid}, 32'd0);
        checkOutput("idle_ram_we",      {31'b0, ram_we},   32'd0);
        checkOutput("idle_ram_addr",    ram_addr,          32'h0);

        // Starvation: both ports request every cycle, DMA single-beat writes.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h100, 32'hC0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hD0);
            checkOutput($sformatf("starve_c_gnt_%0d", i), {31'b0, c_gnt},
                        ((i % 5) != 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starve_d_gnt_%0d", i), {31'b0, d_gnt},
                        ((i % 5) == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starve_stall_%0d", i), {31'b0, c_stall},
                        ((i % 5) == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starve_addr_%0d", i), ram_addr,
                        ((i % 5) == 4) ? 32'h200 : 32'h100);
        end
        idleCycle();

        // Burst cap: six DMA read beats with the CPU idle, all granted.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h300 + i, 32'h0);
            checkOutput($sformatf("burst_d_gnt_%0d", i), {31'b0, d_gnt}, 32'd1);
            checkOutput($sformatf("burst_addr_%0d", i), ram_addr, 32'h300 + i);
            if (i > 0) begin
                checkOutput($sformatf("burst_d_rvalid_%0d", i), {31'b0, d_rvalid}, 32'd1);
            end
        end
        idleCycle();
        checkOutput("burst_tail_rvalid", {31'b0, d_rvalid}, 32'd1);

        // Burst cap with the CPU arriving at beat 2: CPU waits for beat 4.
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i > 0), 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
            checkOutput($sformatf("cap_d_gnt_%0d", i), {31'b0, d_gnt},
                        (i < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cap_c_gnt_%0d", i), {31'b0, c_gnt},
                        (i == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cap_stall_%0d", i), {31'b0, c_stall},
                        ((i > 0) && (i < 4)) ? 32'd1 : 32'd0);
        end
        idleCycle();

        // Early burst end: d_last on beat 2 returns to CPU priority.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h55);
        checkOutput("early_b1_d_gnt", {31'b0, d_gnt}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 1'b1, 32'h504, 32'h56);
        checkOutput("early_b2_d_gnt", {31'b0, d_gnt},   32'd1);
        checkOutput("early_b2_stall", {31'b0, c_stall}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h66);
        checkOutput("early_c_gnt", {31'b0, c_gnt}, 32'd1);
        checkOutput("early_d_gnt", {31'b0, d_gnt}, 32'd0);
        idleCycle();

        // DMA drops its request mid-burst: the CPU gets that same cycle.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h77);
        checkOutput("drop_b1_d_gnt", {31'b0, d_gnt}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h70, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("drop_c_gnt",   {31'b0, c_gnt},  32'd1);
        checkOutput("drop_ram_we",  {31'b0, ram_we}, 32'd1);
        checkOutput("drop_ram_addr", ram_addr,       32'h70);
        idleCycle();

        // Reset mid-burst on beat 2 of a DMA read burst.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0);
        checkOutput("mid_b1_d_gnt", {31'b0, d_gnt}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h804, 32'h0);
        checkOutput("mid_b2_d_gnt",    {31'b0, d_gnt},    32'd1);
        checkOutput("mid_b2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        #1 clrn = 1'b0;
        #1;
        checkOutput("mid_rst_d_gnt",    {31'b0, d_gnt},    32'd0);
        checkOutput("mid_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // After release the arbiter behaves as from a clean reset: four CPU
        // grants, then the DMA is forced in.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h900, 32'h9, 1'b1, 1'b0, 1'b1, 32'hA00, 32'h0);
            if (i == 0) begin
                clrn = 1'b1;
                #1;
                checkOutput("post_d_rvalid", {31'b0, d_rvalid}, 32'd0);
            end
            checkOutput($sformatf("post_c_gnt_%0d", i), {31'b0, c_gnt},
                        (i < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("post_d_gnt_%0d", i), {31'b0, d_gnt},
                        (i == 4) ? 32'd1 : 32'd0);
        end
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU MEM stage (port C) and a DMA/loader engine (port D).
- Sits between the E/M pipeline register outputs and the data RAM.
- Resolves conflicts by giving the CPU priority, with a bounded DMA starvation guarantee and bounded DMA bursts.
- Drives a stall back to the pipeline whenever the CPU is denied the RAM.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive denied DMA cycles (1..15) after which DMA is force-granted over the CPU.
- BURST_MAX, 4, maximum number of consecutive DMA beats per grant (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- c_req  in  1  CPU access request (valid for the current cycle).
- c_we  in  1  CPU write enable.
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU granted this cycle (combinational).
- c_stall  out  1  c_req && !c_gnt; freezes the pipeline.
- c_rvalid  out  1  CPU read data valid (one cycle after grant).
- c_rdata  out  DATA_W  CPU read data.
- d_req  in  1  DMA request.
- d_we  in  1  DMA write enable.
- d_last  in  1  final beat of the DMA burst.
- d_addr  in  ADDR_W  DMA address.
- d_wdata  in  DATA_W  DMA write data.
- d_gnt  out  1  DMA granted this cycle (combinational).
- d_rvalid  out  1  DMA read data valid.
- d_rdata  out  DATA_W  DMA read data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the address is presented.

Behaviour:
- Reset (clrn=0, asynchronous): state=S_CPU, starve_cnt=0, beat_cnt=0, c_rvalid=0, d_rvalid=0.
  - Reset mid-burst aborts the burst immediately.
  - Read data in flight at reset is discarded; no rvalid is ever produced for it.
- FSM states: S_CPU (CPU-priority arbitration) and S_DMA (DMA burst in progress).
- Grant logic is combinational from the current state, the requests and the counters. At most one grant per cycle.
  - S_CPU:
    - Grant C if c_req && starve_cnt < STARVE_MAX.
    - Otherwise grant D if d_req.
    - Otherwise grant neither.
  - S_DMA:
    - Grant D if d_req.
    - If d_req=0, the burst ends; grant C if c_req, using the same cycle.
- Transitions:
  - S_CPU->S_DMA on d_gnt && !d_last && BURST_MAX>1; set beat_cnt=1.
  - In S_DMA, each d_gnt increments beat_cnt.
  - S_DMA->S_CPU when any of: d_gnt && d_last; d_gnt && beat_cnt==BURST_MAX-1; d_req=0. On return, beat_cnt=0.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each cycle with d_req && !d_gnt.
  - Clears on d_gnt.
  - Also clears on any cycle with d_req=0.
- RAM mux:
  - The granted port's we/addr/wdata drive the RAM.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - c_rvalid <= c_gnt && !c_we; d_rvalid <= d_gnt && !d_we.
  - c_rdata and d_rdata both equal ram_rdata; they are meaningful only while the matching rvalid=1.
  - Write latency is 0; a write commits at the edge of the grant cycle.
- Simultaneous c_req and d_req in S_CPU with starve_cnt<STARVE_MAX: C wins and starve_cnt increments.
- While D is granted with c_req=1: c_stall=1.
  - Worst-case CPU stall is BURST_MAX cycles.
  - Worst-case DMA wait is STARVE_MAX cycles.
- A requester keeps req/addr/we/wdata stable until granted. The arbiter does not latch request fields.

Decomposition:
- Shared package holds:
  - State encoding constants S_CPU=1'b0, S_DMA=1'b1.
  - Default widths ADDR_W/DATA_W=32.
- One sub-module: arb_sat_counter, a 4-bit saturating counter with inc, clr and limit inputs and async clear. It is used for starve_cnt and beat_cnt.
- The FSM, grant logic and mux stay in dmem_arbiter.

Test Plan:
- Reset: hold clrn=0 with c_req=d_req=1 -> all grants 0, both rvalid=0, ram_we=0. Release reset -> C granted first cycle.
- CPU only: C read addr 0x10, then write 0x14 data 0xDEADBEEF.
  - Read cycle: c_gnt=1, c_stall=0; c_rvalid=1 exactly one cycle later.
  - Write cycle: ram_we=1, ram_addr=0x14.
- Starvation: c_req=1 and d_req=1 held continuously.
  - C is granted cycles 0-3.
  - Cycle 4: D force-granted, c_stall=1, starve_cnt cleared.
  - Pattern repeats every 5 cycles with d_last=1.
- Burst cap: c_req=0, d_req=1 for 6 beats, d_last=0.
  - D granted beats 1-4, FSM returns to S_CPU after beat 4.
  - Beat 5 is granted again from S_CPU because C is idle.
  - With c_req=1 raised at beat 2: C is granted on the cycle after beat 4.
- Early burst end: D burst with d_last=1 on beat 2 -> state returns to S_CPU. A pending c_req is granted in the next cycle.
- Reset mid-burst: assert clrn=0 during beat 2 of a DMA read burst -> d_gnt=0 and d_rvalid=0 immediately. After release, starve_cnt=0 and state=S_CPU.
